ahb_apb_bridge: RTL and testbench

AHB-Lite slave to APB4 master bridge that sits directly downstream of the team's AHB master and converts each single AHB transfer into one APB setup/access sequence toward a single APB peripheral. It inserts AHB wait states until the APB slave completes, returns read data, and maps APB slave errors, timeouts and illegal transfers onto the AHB two-cycle ERROR response.

---
 rtl/ahb_apb_pkg.sv | 36 +++
 rtl/ahb_apb_bridge_if.sv | 41 ++++
 rtl/ahb_apb_strobe_gen.sv | 36 +++
 rtl/ahb_apb_bridge.sv | 145 ++++++++++++++
 tb/tb_ahb_apb_bridge.sv | 345 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ahb_apb_pkg.sv
// Shared encodings for the AHB-Lite to APB4 bridge: bus codes, FSM states
// and a helper that decides whether an HTRANS value carries a real transfer.
package ahb_apb_pkg;

   localparam logic [1:0] HTRANS_IDLE   = 2'b00;
   localparam logic [1:0] HTRANS_BUSY   = 2'b01;
   localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
   localparam logic [1:0] HTRANS_SEQ    = 2'b11;

   localparam logic [2:0] HSIZE_BYTE = 3'b000;
   localparam logic [2:0] HSIZE_HALF = 3'b001;
   localparam logic [2:0] HSIZE_WORD = 3'b010;

   localparam logic HRESP_OKAY  = 1'b0;
   localparam logic HRESP_ERROR = 1'b1;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_WWAIT  = 3'd1,
      ST_SETUP  = 3'd2,
      ST_ACCESS = 3'd3,
      ST_ERR1   = 3'd4,
      ST_ERR2   = 3'd5
   } state_e;

   function automatic logic trans_active(input logic [1:0] i_trans);
      logic v;
      case (i_trans)
         HTRANS_IDLE, HTRANS_BUSY:  v = 1'b0;
         HTRANS_NONSEQ, HTRANS_SEQ: v = 1'b1;
         default:                   v = 1'b0;
      endcase
      return v;
   endfunction

endpackage

// File: rtl/ahb_apb_bridge_if.sv
// Bus bundle between the AHB master side and the APB peripheral side of the
// bridge; the slave modport is the bridge's own view.
interface ahb_apb_bridge_if #(
   parameter int ADDR_WIDTH  = 32,
   parameter int PADDR_WIDTH = 16
);
   logic                   HSEL;
   logic [ADDR_WIDTH-1:0]  HADDR;
   logic [1:0]             HTRANS;
   logic                   HWRITE;
   logic [2:0]             HSIZE;
   logic [31:0]            HWDATA;
   logic                   HREADY;
   logic                   HREADYOUT;
   logic                   HRESP;
   logic [31:0]            HRDATA;
   logic                   PSEL;
   logic                   PENABLE;
   logic                   PWRITE;
   logic [PADDR_WIDTH-1:0] PADDR;
   logic [31:0]            PWDATA;
   logic [3:0]             PSTRB;
   logic [31:0]            PRDATA;
   logic                   PREADY;
   logic                   PSLVERR;

   modport slave (
      input  HSEL, HADDR, HTRANS, HWRITE, HSIZE, HWDATA, HREADY,
      input  PRDATA, PREADY, PSLVERR,
      output HREADYOUT, HRESP, HRDATA,
      output PSEL, PENABLE, PWRITE, PADDR, PWDATA, PSTRB
   );

   modport master (
      output HSEL, HADDR, HTRANS, HWRITE, HSIZE, HWDATA, HREADY,
      output PRDATA, PREADY, PSLVERR,
      input  HREADYOUT, HRESP, HRDATA,
      input  PSEL, PENABLE, PWRITE, PADDR, PWDATA, PSTRB
   );

endinterface

// File: rtl/ahb_apb_strobe_gen.sv
// Byte-lane strobe decode from HSIZE and the low address bits; flags sizes
// above a word and misaligned halfword/word accesses as illegal.
module ahb_apb_strobe_gen
   import ahb_apb_pkg::*;
(
   input  logic [2:0] i_hsize,
   input  logic [1:0] i_addr_lo,
   output logic [3:0] o_strb,
   output logic       o_illegal
);

   // Strobe and legality decode
   always_comb begin
      o_strb    = 4'b0000;
      o_illegal = 1'b0;
      case (i_hsize)
         HSIZE_BYTE: begin
            o_strb    = 4'b0001 << i_addr_lo;
            o_illegal = 1'b0;
         end
         HSIZE_HALF: begin
            o_strb    = 4'b0011 << {i_addr_lo[1], 1'b0};
            o_illegal = i_addr_lo[0];
         end
         HSIZE_WORD: begin
            o_strb    = 4'b1111;
            o_illegal = (i_addr_lo != 2'b00);
         end
         default: begin
            o_strb    = 4'b0000;
            o_illegal = 1'b1;
         end
      endcase
   end

endmodule

// File: rtl/ahb_apb_bridge.sv
// AHB-Lite slave to APB4 master bridge: one APB setup/access per accepted AHB
// transfer, wait states until PREADY, and a two-cycle ERROR on failure.
module ahb_apb_bridge
   import ahb_apb_pkg::*;
#(
   parameter int ADDR_WIDTH     = 32,
   parameter int PADDR_WIDTH    = 16,
   parameter int TIMEOUT_CYCLES = 256
) (
   input  logic            HCLK,
   input  logic            HRESETn,
   ahb_apb_bridge_if.slave bus
);

   localparam int TW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
   localparam logic [TW-1:0] TCNT_LAST =
      (TIMEOUT_CYCLES > 0) ? TW'(TIMEOUT_CYCLES - 1) : {TW{1'b0}};

   state_e                 r_state;
   state_e                 w_state_nxt;
   logic                   w_accept;
   logic                   w_start;
   logic                   w_illegal;
   logic                   w_timeout;
   logic                   w_unused_addr;
   logic [3:0]             w_strb;
   logic                   r_hreadyout;
   logic                   r_hresp;
   logic [31:0]            r_hrdata;
   logic                   r_psel;
   logic                   r_penable;
   logic                   r_pwrite;
   logic [PADDR_WIDTH-1:0] r_paddr;
   logic [31:0]            r_pwdata;
   logic [3:0]             r_pstrb;
   logic [TW-1:0]          r_tcnt;

   ahb_apb_strobe_gen u_strobe (
      .i_hsize   (bus.HSIZE),
      .i_addr_lo (bus.HADDR[1:0]),
      .o_strb    (w_strb),
      .o_illegal (w_illegal)
   );

   assign w_accept      = bus.HSEL && bus.HREADY && trans_active(bus.HTRANS);
   assign w_start       = w_accept && ((r_state == ST_IDLE) || (r_state == ST_ERR2));
   assign w_timeout     = (TIMEOUT_CYCLES > 0) && !bus.PREADY && (r_tcnt == TCNT_LAST);
   assign w_unused_addr = ^bus.HADDR[ADDR_WIDTH-1:PADDR_WIDTH];

   // Next-state decode; PREADY takes priority over an expiring timeout
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_IDLE, ST_ERR2: begin
            if (!w_start) begin
               w_state_nxt = ST_IDLE;
            end else if (w_illegal) begin
               w_state_nxt = ST_ERR1;
            end else if (bus.HWRITE) begin
               w_state_nxt = ST_WWAIT;
            end else begin
               w_state_nxt = ST_SETUP;
            end
         end
         ST_WWAIT: w_state_nxt = ST_SETUP;
         ST_SETUP: w_state_nxt = ST_ACCESS;
         ST_ACCESS: begin
            if (bus.PREADY) begin
               w_state_nxt = bus.PSLVERR ? ST_ERR1 : ST_IDLE;
            end else if (w_timeout) begin
               w_state_nxt = ST_ERR1;
            end else begin
               w_state_nxt = ST_ACCESS;
            end
         end
         ST_ERR1: w_state_nxt = ST_ERR2;
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   // State and handshake outputs, registered from the next state
   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         r_state     <= ST_IDLE;
         r_hreadyout <= 1'b1;
         r_hresp     <= HRESP_OKAY;
         r_psel      <= 1'b0;
         r_penable   <= 1'b0;
      end else begin
         r_state     <= w_state_nxt;
         r_hreadyout <= (w_state_nxt == ST_IDLE) || (w_state_nxt == ST_ERR2);
         r_hresp     <= ((w_state_nxt == ST_ERR1) || (w_state_nxt == ST_ERR2)) ?
                        HRESP_ERROR : HRESP_OKAY;
         r_psel      <= (w_state_nxt == ST_SETUP) || (w_state_nxt == ST_ACCESS);
         r_penable   <= (w_state_nxt == ST_ACCESS);
      end
   end

   // Transfer attributes are captured only for legal transfers and held after
   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         r_paddr  <= {PADDR_WIDTH{1'b0}};
         r_pwrite <= 1'b0;
         r_pstrb  <= 4'b0000;
         r_pwdata <= 32'h0000_0000;
      end else begin
         if (w_start && !w_illegal) begin
            r_paddr  <= bus.HADDR[PADDR_WIDTH-1:0];
            r_pwrite <= bus.HWRITE;
            r_pstrb  <= bus.HWRITE ? w_strb : 4'b0000;
         end
         if (r_state == ST_WWAIT) begin
            r_pwdata <= bus.HWDATA;
         end
      end
   end

   // Read data return and ACCESS-cycle timeout counter
   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         r_hrdata <= 32'h0000_0000;
         r_tcnt   <= {TW{1'b0}};
      end else begin
         if ((r_state == ST_ACCESS) && bus.PREADY && !bus.PSLVERR && !r_pwrite) begin
            r_hrdata <= bus.PRDATA;
         end
         if (r_state == ST_SETUP) begin
            r_tcnt <= {TW{1'b0}};
         end else if ((r_state == ST_ACCESS) && !bus.PREADY && (TIMEOUT_CYCLES > 0)) begin
            r_tcnt <= r_tcnt + {{(TW-1){1'b0}}, 1'b1};
         end
      end
   end

   assign bus.HREADYOUT = r_hreadyout;
   assign bus.HRESP     = r_hresp;
   assign bus.HRDATA    = r_hrdata;
   assign bus.PSEL      = r_psel;
   assign bus.PENABLE   = r_penable;
   assign bus.PWRITE    = r_pwrite;
   assign bus.PADDR     = r_paddr;
   assign bus.PWDATA    = r_pwdata;
   assign bus.PSTRB     = r_pstrb;

endmodule

// File: tb/tb_ahb_apb_bridge.sv
// Directed bench for ahb_apb_bridge: one DUT with a 4-cycle timeout and one
// with the timeout disabled, checked cycle by cycle against hand timelines.
module tb_ahb_apb_bridge;

   logic HCLK = 1'b0;
   logic HRESETn;
   int   checks = 0;
   int   errors = 0;

   always #5 HCLK = ~HCLK;

   ahb_apb_bridge_if #(.ADDR_WIDTH(32), .PADDR_WIDTH(16)) bus  ();
   ahb_apb_bridge_if #(.ADDR_WIDTH(32), .PADDR_WIDTH(16)) bus0 ();

   assign bus.HREADY  = bus.HREADYOUT;
   assign bus0.HREADY = bus0.HREADYOUT;

   ahb_apb_bridge #(.ADDR_WIDTH(32), .PADDR_WIDTH(16), .TIMEOUT_CYCLES(4)) u_dut (
      .HCLK(HCLK), .HRESETn(HRESETn), .bus(bus));

   ahb_apb_bridge #(.ADDR_WIDTH(32), .PADDR_WIDTH(16), .TIMEOUT_CYCLES(0)) u_dut0 (
      .HCLK(HCLK), .HRESETn(HRESETn), .bus(bus0));

   task automatic step();
      @(posedge HCLK);
      #1;
   endtask

   task automatic ahb_addr(input logic sel, input logic [31:0] addr, input logic [1:0] trans,
                           input logic wr, input logic [2:0] size);
      bus.HSEL = sel; bus.HADDR = addr; bus.HTRANS = trans; bus.HWRITE = wr; bus.HSIZE = size;
   endtask

   task automatic ahb_idle();
      bus.HSEL = 1'b0; bus.HTRANS = 2'b00;
   endtask

   task automatic test_reset();
      repeat (2) step();
      checks++;
      if ({bus.HREADYOUT, bus.HRESP, bus.PSEL, bus.PENABLE, bus.PWRITE} !== 5'b10000) begin
         errors++; $display("FAIL reset_ctrl: got %b expected 10000",
                            {bus.HREADYOUT, bus.HRESP, bus.PSEL, bus.PENABLE, bus.PWRITE});
      end
      checks++;
      if ({bus.HRDATA, bus.PWDATA, bus.PADDR, bus.PSTRB} !== 84'h0) begin
         errors++; $display("FAIL reset_data: got %h expected 0",
                            {bus.HRDATA, bus.PWDATA, bus.PADDR, bus.PSTRB});
      end
      checks++;
      if ({bus0.HREADYOUT, bus0.HRESP, bus0.PSEL, bus0.HRDATA} !== {3'b100, 32'h0}) begin
         errors++; $display("FAIL reset_dut0: got %h expected %h",
                            {bus0.HREADYOUT, bus0.HRESP, bus0.PSEL, bus0.HRDATA}, {3'b100, 32'h0});
      end
      HRESETn = 1'b1;
      step();
   endtask

   task automatic test_idle_trans();
      ahb_addr(1'b1, 32'h0000_0900, 2'b01, 1'b0, 3'b010);
      step();
      checks++;
      if ({bus.HREADYOUT, bus.HRESP, bus.PSEL} !== 3'b100) begin
         errors++; $display("FAIL busy_zero_wait: got %b expected 100", {bus.HREADYOUT, bus.HRESP, bus.PSEL});
      end
      ahb_addr(1'b0, 32'h0000_0900, 2'b10, 1'b0, 3'b010);
      step();
      checks++;
      if ({bus.HREADYOUT, bus.HRESP, bus.PSEL} !== 3'b100) begin
         errors++; $display("FAIL unsel_zero_wait: got %b expected 100", {bus.HREADYOUT, bus.HRESP, bus.PSEL});
      end
      ahb_idle();
   endtask

   task automatic test_read();
      ahb_addr(1'b1, 32'h0000_1004, 2'b10, 1'b0, 3'b010);
      bus.PREADY = 1'b1; bus.PRDATA = 32'hCAFE_F00D;
      step();
      ahb_idle();
      checks++;
      if ({bus.PSEL, bus.PENABLE, bus.HREADYOUT, bus.PWRITE, bus.PSTRB, bus.PADDR} !== {8'b1000_0000, 16'h1004}) begin
         errors++; $display("FAIL read_setup: got %h expected %h",
                            {bus.PSEL, bus.PENABLE, bus.HREADYOUT, bus.PWRITE, bus.PSTRB, bus.PADDR}, {8'b1000_0000, 16'h1004});
      end
      step();
      checks++;
      if ({bus.PSEL, bus.PENABLE, bus.HREADYOUT} !== 3'b110) begin
         errors++; $display("FAIL read_access: got %b expected 110", {bus.PSEL, bus.PENABLE, bus.HREADYOUT});
      end
      step();
      checks++;
      if ({bus.HREADYOUT, bus.HRESP, bus.PSEL, bus.PENABLE, bus.HRDATA} !== {4'b1000, 32'hCAFE_F00D}) begin
         errors++; $display("FAIL read_done: got %h expected %h",
                            {bus.HREADYOUT, bus.HRESP, bus.PSEL, bus.PENABLE, bus.HRDATA}, {4'b1000, 32'hCAFE_F00D});
      end
   endtask

   task automatic test_write_wait();
      ahb_addr(1'b1, 32'h0000_2003, 2'b10, 1'b1, 3'b000);
      bus.PREADY = 1'b0;
      step();
      ahb_idle(); bus.HWDATA = 32'hAA00_0000;
      checks++;
      if ({bus.HREADYOUT, bus.PSEL} !== 2'b00) begin
         errors++; $display("FAIL write_wwait: got %b expected 00", {bus.HREADYOUT, bus.PSEL});
      end
      step();
      bus.HWDATA = 32'h1234_5678;
      checks++;
      if ({bus.PSEL, bus.PENABLE, bus.PWRITE, bus.PSTRB, bus.PADDR, bus.PWDATA} !== {3'b101, 4'b1000, 16'h2003, 32'hAA00_0000}) begin
         errors++; $display("FAIL write_setup: got %h expected %h",
                            {bus.PSEL, bus.PENABLE, bus.PWRITE, bus.PSTRB, bus.PADDR, bus.PWDATA},
                            {3'b101, 4'b1000, 16'h2003, 32'hAA00_0000});
      end
      for (int i = 0; i < 3; i++) begin
         step();
         checks++;
         if ({bus.PSEL, bus.PENABLE, bus.HREADYOUT, bus.PWDATA} !== {3'b110, 32'hAA00_0000}) begin
            errors++; $display("FAIL write_wait%0d: got %h expected %h", i,
                               {bus.PSEL, bus.PENABLE, bus.HREADYOUT, bus.PWDATA}, {3'b110, 32'hAA00_0000});
         end
      end
      step();
      bus.PREADY = 1'b1;
      checks++;
      if ({bus.PSEL, bus.PENABLE, bus.HREADYOUT} !== 3'b110) begin
         errors++; $display("FAIL write_last_access: got %b expected 110", {bus.PSEL, bus.PENABLE, bus.HREADYOUT});
      end
      step();
      checks++;
      if ({bus.HREADYOUT, bus.HRESP, bus.PSEL, bus.PENABLE, bus.PSTRB, bus.HRDATA} !== {8'b1000_1000, 32'hCAFE_F00D}) begin
         errors++; $display("FAIL write_done: got %h expected %h",
                            {bus.HREADYOUT, bus.HRESP, bus.PSEL, bus.PENABLE, bus.PSTRB, bus.HRDATA}, {8'b1000_1000, 32'hCAFE_F00D});
      end
   endtask

   task automatic test_slverr();
      ahb_addr(1'b1, 32'h0000_3000, 2'b10, 1'b1, 3'b010);
      bus.PREADY = 1'b1; bus.PSLVERR = 1'b1;
      step();
      ahb_idle(); bus.HWDATA = 32'h0000_0055;
      step();
      step();
      checks++;
      if (bus.PENABLE !== 1'b1) begin
         errors++; $display("FAIL slverr_access: got %b expected 1", bus.PENABLE);
      end
      step();
      checks++;
      if ({bus.HRESP, bus.HREADYOUT, bus.PSEL, bus.PENABLE} !== 4'b1000) begin
         errors++; $display("FAIL slverr_err1: got %b expected 1000", {bus.HRESP, bus.HREADYOUT, bus.PSEL, bus.PENABLE});
      end
      step();
      checks++;
      if ({bus.HRESP, bus.HREADYOUT, bus.PSEL} !== 3'b110) begin
         errors++; $display("FAIL slverr_err2: got %b expected 110", {bus.HRESP, bus.HREADYOUT, bus.PSEL});
      end
      ahb_addr(1'b1, 32'h0000_0040, 2'b10, 1'b0, 3'b010);
      bus.PSLVERR = 1'b0; bus.PRDATA = 32'h1357_9BDF;
      step();
      ahb_idle();
      checks++;
      if ({bus.HRESP, bus.HREADYOUT, bus.PSEL, bus.PENABLE, bus.PWRITE, bus.PSTRB, bus.PADDR} !== {9'b0010_0_0000, 16'h0040}) begin
         errors++; $display("FAIL err2_accept_setup: got %h expected %h",
                            {bus.HRESP, bus.HREADYOUT, bus.PSEL, bus.PENABLE, bus.PWRITE, bus.PSTRB, bus.PADDR}, {9'b0010_0_0000, 16'h0040});
      end
      step();
      step();
      checks++;
      if ({bus.HREADYOUT, bus.HRESP, bus.HRDATA} !== {2'b10, 32'h1357_9BDF}) begin
         errors++; $display("FAIL err2_read_done: got %h expected %h", {bus.HREADYOUT, bus.HRESP, bus.HRDATA}, {2'b10, 32'h1357_9BDF});
      end
   endtask

   task automatic test_illegal();
      logic [2:0]  sizes [2] = '{3'b011, 3'b001};
      logic [31:0] addrs [2] = '{32'h0000_0100, 32'h0000_0201};
      logic        wrs   [2] = '{1'b0, 1'b1};
      for (int v = 0; v < 2; v++) begin
         ahb_addr(1'b1, addrs[v], 2'b10, wrs[v], sizes[v]);
         step();
         ahb_idle();
         checks++;
         if ({bus.HRESP, bus.HREADYOUT, bus.PSEL} !== 3'b100) begin
            errors++; $display("FAIL illegal%0d_err1: got %b expected 100", v, {bus.HRESP, bus.HREADYOUT, bus.PSEL});
         end
         step();
         checks++;
         if ({bus.HRESP, bus.HREADYOUT, bus.PSEL} !== 3'b110) begin
            errors++; $display("FAIL illegal%0d_err2: got %b expected 110", v, {bus.HRESP, bus.HREADYOUT, bus.PSEL});
         end
         step();
         checks++;
         if ({bus.HRESP, bus.HREADYOUT, bus.PSEL} !== 3'b010) begin
            errors++; $display("FAIL illegal%0d_after: got %b expected 010", v, {bus.HRESP, bus.HREADYOUT, bus.PSEL});
         end
      end
   endtask

   task automatic test_timeout();
      ahb_addr(1'b1, 32'h0000_0500, 2'b10, 1'b0, 3'b010);
      bus.PREADY = 1'b0;
      step();
      ahb_idle();
      for (int i = 0; i < 4; i++) begin
         step();
         checks++;
         if ({bus.PSEL, bus.PENABLE, bus.HREADYOUT, bus.HRESP} !== 4'b1100) begin
            errors++; $display("FAIL timeout_access%0d: got %b expected 1100", i,
                               {bus.PSEL, bus.PENABLE, bus.HREADYOUT, bus.HRESP});
         end
      end
      step();
      checks++;
      if ({bus.PSEL, bus.PENABLE, bus.HRESP, bus.HREADYOUT} !== 4'b0010) begin
         errors++; $display("FAIL timeout_err1: got %b expected 0010", {bus.PSEL, bus.PENABLE, bus.HRESP, bus.HREADYOUT});
      end
      step();
      checks++;
      if ({bus.PSEL, bus.PENABLE, bus.HRESP, bus.HREADYOUT} !== 4'b0011) begin
         errors++; $display("FAIL timeout_err2: got %b expected 0011", {bus.PSEL, bus.PENABLE, bus.HRESP, bus.HREADYOUT});
      end
      bus.PREADY = 1'b1;
      step();
      checks++;
      if ({bus.HRESP, bus.HREADYOUT, bus.HRDATA} !== {2'b01, 32'h1357_9BDF}) begin
         errors++; $display("FAIL timeout_after: got %h expected %h", {bus.HRESP, bus.HREADYOUT, bus.HRDATA}, {2'b01, 32'h1357_9BDF});
      end
   endtask

   task automatic test_no_timeout();
      bus0.HSEL = 1'b1; bus0.HADDR = 32'h0000_0ABC; bus0.HTRANS = 2'b10;
      bus0.HWRITE = 1'b0; bus0.HSIZE = 3'b010; bus0.PREADY = 1'b0;
      step();
      bus0.HSEL = 1'b0; bus0.HTRANS = 2'b00;
      repeat (40) step();
      checks++;
      if ({bus0.PSEL, bus0.PENABLE, bus0.HREADYOUT, bus0.HRESP} !== 4'b1100) begin
         errors++; $display("FAIL notimeout_hold: got %b expected 1100", {bus0.PSEL, bus0.PENABLE, bus0.HREADYOUT, bus0.HRESP});
      end
      bus0.PREADY = 1'b1; bus0.PRDATA = 32'h0BAD_CAFE;
      step();
      checks++;
      if ({bus0.HREADYOUT, bus0.HRESP, bus0.PSEL, bus0.HRDATA} !== {3'b100, 32'h0BAD_CAFE}) begin
         errors++; $display("FAIL notimeout_done: got %h expected %h",
                            {bus0.HREADYOUT, bus0.HRESP, bus0.PSEL, bus0.HRDATA}, {3'b100, 32'h0BAD_CAFE});
      end
   endtask

   task automatic test_back_to_back();
      ahb_addr(1'b1, 32'h0000_0010, 2'b10, 1'b0, 3'b010);
      bus.PREADY = 1'b1; bus.PRDATA = 32'h1111_2222;
      step();
      ahb_idle();
      step();
      step();
      checks++;
      if ({bus.HREADYOUT, bus.PSEL, bus.HRDATA} !== {2'b10, 32'h1111_2222}) begin
         errors++; $display("FAIL b2b_read_done: got %h expected %h", {bus.HREADYOUT, bus.PSEL, bus.HRDATA}, {2'b10, 32'h1111_2222});
      end
      ahb_addr(1'b1, 32'h0000_0702, 2'b10, 1'b1, 3'b001);
      bus.PRDATA = 32'hFFFF_FFFF;
      step();
      ahb_idle(); bus.HWDATA = 32'hBEEF_0000;
      checks++;
      if ({bus.HREADYOUT, bus.PSEL} !== 2'b00) begin
         errors++; $display("FAIL b2b_wwait: got %b expected 00", {bus.HREADYOUT, bus.PSEL});
      end
      step();
      checks++;
      if ({bus.PSEL, bus.PENABLE, bus.PWRITE, bus.PSTRB, bus.PADDR, bus.PWDATA} !== {3'b101, 4'b1100, 16'h0702, 32'hBEEF_0000}) begin
         errors++; $display("FAIL b2b_half_setup: got %h expected %h",
                            {bus.PSEL, bus.PENABLE, bus.PWRITE, bus.PSTRB, bus.PADDR, bus.PWDATA},
                            {3'b101, 4'b1100, 16'h0702, 32'hBEEF_0000});
      end
      step();
      step();
      checks++;
      if ({bus.HREADYOUT, bus.HRESP, bus.PSEL, bus.HRDATA} !== {3'b100, 32'h1111_2222}) begin
         errors++; $display("FAIL b2b_write_done: got %h expected %h",
                            {bus.HREADYOUT, bus.HRESP, bus.PSEL, bus.HRDATA}, {3'b100, 32'h1111_2222});
      end
   endtask

   task automatic test_reset_mid();
      ahb_addr(1'b1, 32'h0000_0600, 2'b10, 1'b0, 3'b010);
      bus.PREADY = 1'b0;
      step();
      ahb_idle();
      step();
      checks++;
      if (bus.PENABLE !== 1'b1) begin
         errors++; $display("FAIL rstmid_pre: got %b expected 1", bus.PENABLE);
      end
      HRESETn = 1'b0;
      #1;
      checks++;
      if ({bus.PSEL, bus.PENABLE, bus.HREADYOUT, bus.HRESP, bus.PADDR, bus.HRDATA} !== {4'b0010, 48'h0}) begin
         errors++; $display("FAIL rstmid_outputs: got %h expected %h",
                            {bus.PSEL, bus.PENABLE, bus.HREADYOUT, bus.HRESP, bus.PADDR, bus.HRDATA}, {4'b0010, 48'h0});
      end
      step();
      HRESETn = 1'b1; bus.PREADY = 1'b1; bus.PRDATA = 32'h2468_ACE0;
      ahb_addr(1'b1, 32'h0000_0008, 2'b10, 1'b0, 3'b010);
      step();
      ahb_idle();
      checks++;
      if ({bus.PSEL, bus.PENABLE, bus.PADDR} !== {2'b10, 16'h0008}) begin
         errors++; $display("FAIL rstmid_setup: got %h expected %h", {bus.PSEL, bus.PENABLE, bus.PADDR}, {2'b10, 16'h0008});
      end
      step();
      step();
      checks++;
      if ({bus.HREADYOUT, bus.HRESP, bus.HRDATA} !== {2'b10, 32'h2468_ACE0}) begin
         errors++; $display("FAIL rstmid_read_done: got %h expected %h", {bus.HREADYOUT, bus.HRESP, bus.HRDATA}, {2'b10, 32'h2468_ACE0});
      end
   endtask

   initial begin
      HRESETn = 1'b0;
      bus.HSEL = 1'b0; bus.HADDR = 32'h0; bus.HTRANS = 2'b00; bus.HWRITE = 1'b0;
      bus.HSIZE = 3'b000; bus.HWDATA = 32'h0; bus.PRDATA = 32'h0; bus.PREADY = 1'b1; bus.PSLVERR = 1'b0;
      bus0.HSEL = 1'b0; bus0.HADDR = 32'h0; bus0.HTRANS = 2'b00; bus0.HWRITE = 1'b0;
      bus0.HSIZE = 3'b000; bus0.HWDATA = 32'h0; bus0.PRDATA = 32'h0; bus0.PREADY = 1'b1; bus0.PSLVERR = 1'b0;
      test_reset();
      test_idle_trans();
      test_read();
      test_write_wait();
      test_slverr();
      test_illegal();
      test_timeout();
      test_no_timeout();
      test_back_to_back();
      test_reset_mid();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got no completion expected finish within 100000 time units");
      $fatal(1);
   end

endmodule
